syscall_sequencer: RTL and testbench

Multi-cycle sequencer for the MIPS SYSCALL instruction. When decode flags a syscall, the block stalls the pipeline and runs the requested service using `$v0` and `$a0`. For string output it walks data memory one byte at a time and streams the characters to the console port. It sits beside the decode/control stage, owns a byte-read port into data memory, and drives the pipeline stall.

---
 rtl/syscall_sequencer_pkg.sv | 34 +++
 rtl/syscall_sequencer_nibble_to_ascii.sv | 15 +
 rtl/syscall_sequencer.sv | 164 ++++++++++++++++
 tb/tb_syscall_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_sequencer_pkg.sv
// Shared service codes, state encoding and helpers for the SYSCALL sequencer.
// Optional print-hex service is compiled in with SYSCALL_HEX_INT_EN.
package syscall_pkg;

  localparam logic [31:0] SVC_PRINT_STR = 32'd4;
  localparam logic [31:0] SVC_EXIT      = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHR = 32'd11;
  localparam logic [31:0] SVC_PRINT_HEX = 32'd34;

  localparam logic [7:0] NUL = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    STR_REQ,
    STR_WAIT,
    STR_EMIT,
    CHR_EMIT,
    DONE,
    HALT
`ifdef SYSCALL_HEX_INT_EN
    , HEX_EMIT
`endif
  } state_t;

  function automatic logic svc_supported(input logic [31:0] code);
    logic ok;
    ok = (code == SVC_PRINT_STR) || (code == SVC_EXIT) || (code == SVC_PRINT_CHR);
`ifdef SYSCALL_HEX_INT_EN
    ok = ok || (code == SVC_PRINT_HEX);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/syscall_sequencer_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit; zero latency, no flow control.
// Only built when SYSCALL_HEX_INT_EN is defined.
`ifdef SYSCALL_HEX_INT_EN
module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule
`endif

// File: rtl/syscall_sequencer.sv
// SYSCALL service sequencer: stalls the pipeline, streams strings/chars to the console, 3 cycles/char
// at zero wait; holds out_valid/out_data until out_ready. Print-hex (34) enabled by SYSCALL_HEX_INT_EN.
module syscall_sequencer
  import syscall_pkg::*;
#(
  parameter int MAX_STR_LEN = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_valid,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        done,
  output logic        halted,
  output logic        err,
  output logic        trunc
);

  localparam int CW = $clog2(MAX_STR_LEN + 1);

  state_t        state;
  logic [CW-1:0] cnt;

`ifdef SYSCALL_HEX_INT_EN
  logic [31:0] a0_q;
  logic [2:0]  nib_cnt;
  logic [2:0]  hex_idx;
  logic [31:0] hex_src;
  logic [3:0]  hex_nib;
  logic [7:0]  hex_chr;

  // Digit for the next registered out_data: first digit from live a0, later ones from the latched copy.
  always_comb begin
    hex_idx = (state == HEX_EMIT) ? nib_cnt + 3'd1 : 3'd0;
    hex_src = (state == HEX_EMIT) ? a0_q : a0;
    hex_nib = 4'(hex_src >> {3'd7 - hex_idx, 2'b00});
  end

  nibble_to_ascii u_nibble_to_ascii (
    .nibble (hex_nib),
    .ascii  (hex_chr)
  );
`else
  logic unused_a0;
  assign unused_a0 = ^a0[31:8];
`endif

  assign stall = ((state != IDLE) && (state != DONE)) ||
                 ((state == IDLE) && syscall_valid && svc_supported(v0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      trunc     <= 1'b0;
`ifdef SYSCALL_HEX_INT_EN
      a0_q      <= '0;
      nib_cnt   <= '0;
`endif
    end else begin
      done  <= 1'b0;
      trunc <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (syscall_valid) begin
            if (v0 == SVC_PRINT_STR) begin
              state    <= STR_REQ;
              mem_req  <= 1'b1;
              mem_addr <= a0;
              cnt      <= '0;
            end else if (v0 == SVC_PRINT_CHR) begin
              state     <= CHR_EMIT;
              out_valid <= 1'b1;
              out_data  <= a0[7:0];
            end else if (v0 == SVC_EXIT) begin
              state  <= HALT;
              halted <= 1'b1;
`ifdef SYSCALL_HEX_INT_EN
            end else if (v0 == SVC_PRINT_HEX) begin
              state     <= HEX_EMIT;
              a0_q      <= a0;
              nib_cnt   <= '0;
              out_valid <= 1'b1;
              out_data  <= hex_chr;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        STR_REQ: state <= STR_WAIT;
        STR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_rdata == NUL) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= STR_EMIT;
              out_valid <= 1'b1;
              out_data  <= mem_rdata;
            end
          end
        end
        STR_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            mem_addr  <= mem_addr + 32'd1;
            cnt       <= cnt + 1'b1;
            if (cnt + 1'b1 == CW'(MAX_STR_LEN)) begin
              state <= DONE;
              done  <= 1'b1;
              trunc <= 1'b1;
            end else begin
              state   <= STR_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        CHR_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
          end
        end
`ifdef SYSCALL_HEX_INT_EN
        HEX_EMIT: begin
          if (out_ready) begin
            if (nib_cnt == 3'd7) begin
              out_valid <= 1'b0;
              state     <= DONE;
              done      <= 1'b1;
            end else begin
              nib_cnt  <= nib_cnt + 3'd1;
              out_data <= hex_chr;
            end
          end
        end
`endif
        DONE: state <= IDLE;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_sequencer.sv
// Directed self-checking bench for syscall_sequencer (MAX_STR_LEN=4), byte memory modelled at 0x1001000x.
// Hex-service expectations follow SYSCALL_HEX_INT_EN.
module tb_syscall_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_valid;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        done;
  logic        halted;
  logic        err;
  logic        trunc;

  logic [7:0]  mem [0:15];
  logic        ack_en;
  logic        ack_force;
  logic        rdy;

  int checks = 0;
  int errors = 0;

  // Results gathered by run_svc
  logic [7:0]  chars [0:15];
  int          nch;
  int          done_k;
  logic        trunc_d;
  logic        stall_d;
  logic [31:0] last_addr;

  always #5 clk = ~clk;

  assign mem_ack   = ack_force | (mem_req & ack_en);
  assign mem_rdata = mem[mem_addr[3:0]];
  assign out_ready = rdy;

  syscall_sequencer #(.MAX_STR_LEN(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .syscall_valid (syscall_valid),
    .v0            (v0),
    .a0            (a0),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .done          (done),
    .halted        (halted),
    .err           (err),
    .trunc         (trunc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a syscall in cycle T, check stall in T, then move to T+1 with syscall_valid dropped.
  task automatic start_svc(input logic [31:0] code, input logic [31:0] arg, input logic exp_stall);
    syscall_valid = 1'b1;
    v0 = code;
    a0 = arg;
    #1;
    check("stall_in_T", {31'd0, stall}, {31'd0, exp_stall});
    step();
    syscall_valid = 1'b0;
    #1;
  endtask

  // Called in cycle T+1 (k=1); stops in the done cycle or after budget cycles.
  task automatic run_svc(input int budget);
    nch = 0;
    done_k = 0;
    trunc_d = 1'b0;
    stall_d = 1'b1;
    last_addr = '0;
    for (int k = 1; k <= budget; k++) begin
      if (mem_req) last_addr = mem_addr;
      if (out_valid && out_ready && nch < 16) begin
        chars[nch] = out_data;
        nch++;
      end
      if (done) begin
        done_k = k;
        trunc_d = trunc;
        stall_d = stall;
        break;
      end
      step();
    end
    if (done_k == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [63:0] hex_exp;
    int bad;
    reset = 1'b1;
    syscall_valid = 1'b0;
    v0 = '0;
    a0 = '0;
    ack_en = 1'b1;
    ack_force = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    repeat (2) step();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_flags", {28'd0, done, halted, err, trunc}, 32'd0);
    reset = 1'b0;
    step();

    // "Hi": chars at k=3,6; NUL read at k=8; done at T+9
    mem[0] = 8'h48; mem[1] = 8'h69; mem[2] = 8'h00;
    start_svc(32'd4, 32'h1001_0000, 1'b1);
    check("hi_req_T1", {31'd0, mem_req}, 32'd1);
    check("hi_addr_T1", mem_addr, 32'h1001_0000);
    run_svc(30);
    check("hi_done_cycle", done_k, 32'd9);
    check("hi_nchars", nch, 32'd2);
    check("hi_char0", {24'd0, chars[0]}, 32'h48);
    check("hi_char1", {24'd0, chars[1]}, 32'h69);
    check("hi_last_addr", last_addr, 32'h1001_0002);
    check("hi_trunc", {31'd0, trunc_d}, 32'd0);
    check("hi_stall_at_done", {31'd0, stall_d}, 32'd0);
    step();
    check("hi_done_pulse", {31'd0, done}, 32'd0);

    // Print char with console back-pressure for 3 cycles
    rdy = 1'b0;
    start_svc(32'd11, 32'h0000_0141, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("chr_hold_valid", {31'd0, out_valid}, 32'd1);
      check("chr_hold_data", {24'd0, out_data}, 32'h41);
      step();
    end
    rdy = 1'b1;
    check("chr_accept_data", {24'd0, out_data}, 32'h41);
    step();
    check("chr_done", {31'd0, done}, 32'd1);
    check("chr_valid_after", {31'd0, out_valid}, 32'd0);
    step();

    // 8-char string against MAX_STR_LEN=4: done and trunc together at T+13
    for (int i = 0; i < 8; i++) mem[i] = 8'h41 + 8'(i);
    mem[8] = 8'h00;
    start_svc(32'd4, 32'h1001_0000, 1'b1);
    run_svc(40);
    check("tr_done_cycle", done_k, 32'd13);
    check("tr_nchars", nch, 32'd4);
    check("tr_char0", {24'd0, chars[0]}, 32'h41);
    check("tr_char3", {24'd0, chars[3]}, 32'h44);
    check("tr_trunc", {31'd0, trunc_d}, 32'd1);
    check("tr_last_addr", last_addr, 32'h1001_0003);
    step();
    check("tr_trunc_pulse", {31'd0, trunc}, 32'd0);

    // Unsupported code
    start_svc(32'd5, 32'd0, 1'b0);
    check("err5_pulse", {31'd0, err}, 32'd1);
    check("err5_stall", {31'd0, stall}, 32'd0);
    step();
    check("err5_pulse_end", {31'd0, err}, 32'd0);

`ifdef SYSCALL_HEX_INT_EN
    hex_exp = "DEADBEEF";
    start_svc(32'd34, 32'hDEAD_BEEF, 1'b1);
    run_svc(20);
    check("hex_nchars", nch, 32'd8);
    check("hex_done_cycle", done_k, 32'd9);
    for (int i = 0; i < 8; i++)
      check("hex_digit", {24'd0, chars[i]}, {24'd0, hex_exp[63-8*i -: 8]});
    step();
`else
    hex_exp = '0;
    start_svc(32'd34, 32'hDEAD_BEEF, 1'b0);
    check("hex_off_err", {31'd0, err}, 32'd1);
    check("hex_off_stall", {31'd0, stall}, 32'd0);
    check("hex_off_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("hex_off_err_end", {31'd0, err}, 32'd0);
`endif

    // Reset while STR_WAIT is pending, then a stray ack
    ack_en = 1'b0;
    mem[0] = 8'h48;
    start_svc(32'd4, 32'h1001_0000, 1'b1);
    step();
    check("rw_in_wait", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ack_force = 1'b1;
    #1;
    check("rw_outputs", {mem_addr[3:0], out_data, mem_req, out_valid, stall, done, halted, err, trunc},
          32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      ack_force = 1'b0;
      if (out_valid || mem_req || stall || done) bad++;
    end
    check("rw_quiet", bad, 32'd0);
    ack_en = 1'b1;

    // Exit: halted and stall persist until reset
    start_svc(32'd10, 32'd0, 1'b1);
    check("halt_set", {31'd0, halted}, 32'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(halted && stall)) bad++;
      step();
    end
    check("halt_persist", bad, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    check("halt_rst_stall", {31'd0, stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
